dp_sram: RTL and testbench
==========================

DP_SRAM -- requirements
Module: DP_SRAM

Interface
REQ-001 Parameter ROMDATA, default "", hex init file loaded into the array at time 0; empty means no load (array contents X).
REQ-002 Parameter DWIDTH, default 32, data width in bits; SHALL be a multiple of 8.
REQ-003 Parameter AWIDTH, default 12, address width.
REQ-004 Parameter SIZE, default 4096, number of words; SIZE <= 2^AWIDTH.
REQ-005 Parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-006 Parameter RDW_MODE, default 0, cross-port read-during-write: 0 = old data, 1 = new (merged) data.
REQ-007 CLK  input  1  single clock; all state on rising edge.
REQ-008 RSTN  input  1  reset, asynchronous, active-low.
REQ-009 A_CSN  input  1  port A chip select, active-low.
REQ-010 A_ADDR  input  AWIDTH  port A word address.
REQ-011 A_WEN  input  1  port A 1 = read, 0 = write.
REQ-012 A_BE  input  DWIDTH/8  port A byte-lane write enables.
REQ-013 A_DI  input  DWIDTH  port A write data.
REQ-014 A_DOUT  output  DWIDTH  port A read data.
REQ-015 A_VALID  output  1  one-cycle pulse marking fresh A_DOUT.
REQ-016 B_CSN  input  1  port B (read-only) chip select, active-low.
REQ-017 B_ADDR  input  AWIDTH  port B word address.
REQ-018 B_DOUT  output  DWIDTH  port B read data.
REQ-019 B_VALID  output  1  one-cycle pulse marking fresh B_DOUT.
REQ-020 COLL  output  1  one-cycle pulse: A write and B read hit the same address in the same cycle.

Function
REQ-021 A read accepted on edge with ~A_CSN & A_WEN; data on A_DOUT and A_VALID=1 exactly RD_LAT edges later.
REQ-022 A write accepted on edge with ~A_CSN & ~A_WEN; only lanes with A_BE[i]=1 updated (bits 8i+7:8i); A_BE all-zero = no change.
REQ-023 B read accepted on edge with ~B_CSN; same latency/valid rule as REQ-021.
REQ-024 Reads fully pipelined: one new read per port per cycle, back-to-back accepted; no stalls.
REQ-025 A_DOUT/B_DOUT hold last delivered value when VALID=0; writes do not change A_DOUT.
REQ-026 Same edge, A write and B read at same address: RDW_MODE=0 -> B gets pre-write word; RDW_MODE=1 -> B gets word with written lanes merged.
REQ-027 COLL=1 on the edge after a REQ-026 event, for one cycle, in both modes; back-to-back events give continuous COLL.
REQ-028 Address >= SIZE: read returns all-zero with normal VALID timing; write dropped; COLL not raised.
REQ-029 Write followed by A or B read of same address on next edge returns written data (no stale read).
REQ-030 Illegal RD_LAT or DWIDTH%8 != 0: $display error and $finish at time 0.

Reset
REQ-031 RSTN=0 immediately (asynchronously) forces A_DOUT=0, B_DOUT=0, A_VALID=0, B_VALID=0, COLL=0 and clears all read pipeline stages.
REQ-032 Reset mid-read: in-flight reads discarded; no VALID after RSTN rises for requests accepted before reset.
REQ-033 While RSTN=0, no reads or writes accepted; array contents SHALL be preserved through reset.
REQ-034 First request accepted on first rising edge with RSTN=1.

Verification
REQ-035 RD_LAT=1: A write addr 5 DI=0x11223344 BE=4'hF, then A read addr 5 -> next cycle A_DOUT=0x11223344, A_VALID=1 one cycle.
REQ-036 Partial write addr 5 BE=4'b0101 DI=0xAABBCCDD -> read returns 0x11BB33DD.
REQ-037 Same edge A write addr 9 DI=0xFFFFFFFF over 0x0, B read addr 9: RDW_MODE=0 -> B_DOUT=0x0; RDW_MODE=1 -> B_DOUT=0xFFFFFFFF; COLL=1 one cycle in both.
REQ-038 RD_LAT=2: B reads addr 0,1,2 on consecutive edges -> B_VALID high three consecutive cycles starting 2 edges after first, data in order.
REQ-039 RD_LAT=2: A read accepted, RSTN pulsed low before delivery -> outputs 0 immediately, no A_VALID after release, array unchanged on re-read.
REQ-040 SIZE=3000: A write addr 3500 then read addr 3500 -> A_DOUT=0 with A_VALID=1; word at addr 3500-2048 unaffected.

Source files
------------

// File: rtl/dp_sram.sv
// Dual-port SRAM: port A read/write with byte lanes, port B read-only, both reads RD_LAT-cycle pipelined.
// Latency RD_LAT (1 or 2) edges to *_VALID; no backpressure, one read per port per cycle; COLL flags same-address A-write/B-read.
module dp_sram #(
    parameter        ROMDATA  = "",
    parameter int    DWIDTH   = 32,
    parameter int    AWIDTH   = 12,
    parameter int    SIZE     = 4096,
    parameter int    RD_LAT   = 1,
    parameter int    RDW_MODE = 0
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  A_CSN,
    input  logic [AWIDTH-1:0]     A_ADDR,
    input  logic                  A_WEN,
    input  logic [DWIDTH/8-1:0]   A_BE,
    input  logic [DWIDTH-1:0]     A_DI,
    output logic [DWIDTH-1:0]     A_DOUT,
    output logic                  A_VALID,
    input  logic                  B_CSN,
    input  logic [AWIDTH-1:0]     B_ADDR,
    output logic [DWIDTH-1:0]     B_DOUT,
    output logic                  B_VALID,
    output logic                  COLL
);

    localparam int              NBE    = DWIDTH / 8;
    localparam logic [AWIDTH:0] SIZE_W = (AWIDTH + 1)'(SIZE);

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $fatal(1, "dp_sram: RD_LAT must be 1 or 2");
    end
    if (DWIDTH % 8 != 0) begin : g_bad_dw
        $fatal(1, "dp_sram: DWIDTH must be a multiple of 8");
    end

    logic [DWIDTH-1:0] mem [SIZE];

    function automatic logic [DWIDTH-1:0] merge_lanes(input logic [DWIDTH-1:0] old_w,
                                                      input logic [DWIDTH-1:0] new_w,
                                                      input logic [NBE-1:0]    be);
        logic [DWIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < NBE; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    logic              a_in_rng, b_in_rng;
    logic              a_rd_acc, a_wr_acc, b_rd_acc, b_hit;
    logic [DWIDTH-1:0] a_rword, b_rword, a_wword, b_rdat;

    logic [RD_LAT-1:0] a_vld_d, a_vld_q, b_vld_d, b_vld_q;
    logic [DWIDTH-1:0] a_dat_d [RD_LAT];
    logic [DWIDTH-1:0] a_dat_q [RD_LAT];
    logic [DWIDTH-1:0] b_dat_d [RD_LAT];
    logic [DWIDTH-1:0] b_dat_q [RD_LAT];
    logic              coll_d, coll_q;

    always_comb begin
        a_in_rng = {1'b0, A_ADDR} < SIZE_W;
        b_in_rng = {1'b0, B_ADDR} < SIZE_W;
        a_rd_acc = RSTN & ~A_CSN & A_WEN;
        a_wr_acc = RSTN & ~A_CSN & ~A_WEN & a_in_rng;
        b_rd_acc = RSTN & ~B_CSN;
        // Out-of-range reads return zero rather than aliasing into the array
        a_rword  = a_in_rng ? mem[A_ADDR] : '0;
        b_rword  = b_in_rng ? mem[B_ADDR] : '0;
        a_wword  = merge_lanes(a_rword, A_DI, A_BE);
        b_hit    = a_wr_acc & b_rd_acc & b_in_rng & (A_ADDR == B_ADDR);
        b_rdat   = (RDW_MODE != 0 && b_hit) ? a_wword : b_rword;
        coll_d   = b_hit;
    end

    // Each stage loads only when the stage before it carries a read, so the
    // final stage holds the last delivered word while VALID is low.
    always_comb begin
        a_vld_d    = '0;
        b_vld_d    = '0;
        a_dat_d    = a_dat_q;
        b_dat_d    = b_dat_q;
        a_vld_d[0] = a_rd_acc;
        b_vld_d[0] = b_rd_acc;
        if (a_rd_acc) a_dat_d[0] = a_rword;
        if (b_rd_acc) b_dat_d[0] = b_rdat;
        for (int i = 1; i < RD_LAT; i++) begin
            a_vld_d[i] = a_vld_q[i-1];
            b_vld_d[i] = b_vld_q[i-1];
            if (a_vld_q[i-1]) a_dat_d[i] = a_dat_q[i-1];
            if (b_vld_q[i-1]) b_dat_d[i] = b_dat_q[i-1];
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            a_vld_q <= '0;
            b_vld_q <= '0;
            coll_q  <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                a_dat_q[i] <= '0;
                b_dat_q[i] <= '0;
            end
        end else begin
            a_vld_q <= a_vld_d;
            b_vld_q <= b_vld_d;
            coll_q  <= coll_d;
            a_dat_q <= a_dat_d;
            b_dat_q <= b_dat_d;
        end
    end

    // Array has no reset so its contents survive RSTN
    always_ff @(posedge CLK) begin
        if (a_wr_acc) mem[A_ADDR] <= a_wword;
    end

    assign A_DOUT  = a_dat_q[RD_LAT-1];
    assign A_VALID = a_vld_q[RD_LAT-1];
    assign B_DOUT  = b_dat_q[RD_LAT-1];
    assign B_VALID = b_vld_q[RD_LAT-1];
    assign COLL    = coll_q;

endmodule

// File: tb/tb_dp_sram.sv
// Directed bench: three dp_sram instances share stimulus (u0: RD_LAT=1 old-data, u1: RD_LAT=1 new-data, u2: RD_LAT=2 SIZE=3000).
module tb_dp_sram;

    logic        clk, rstn;
    logic        a_csn, a_wen, b_csn;
    logic [11:0] a_addr, b_addr;
    logic [3:0]  a_be;
    logic [31:0] a_di;
    logic [31:0] a_dout [3];
    logic [31:0] b_dout [3];
    logic        a_vld [3];
    logic        b_vld [3];
    logic        coll [3];

    int n_chk  = 0;
    int n_fail = 0;

    dp_sram #(.RD_LAT(1), .RDW_MODE(0)) u0 (
        .CLK(clk), .RSTN(rstn), .A_CSN(a_csn), .A_ADDR(a_addr), .A_WEN(a_wen), .A_BE(a_be),
        .A_DI(a_di), .A_DOUT(a_dout[0]), .A_VALID(a_vld[0]), .B_CSN(b_csn), .B_ADDR(b_addr),
        .B_DOUT(b_dout[0]), .B_VALID(b_vld[0]), .COLL(coll[0]));
    dp_sram #(.RD_LAT(1), .RDW_MODE(1)) u1 (
        .CLK(clk), .RSTN(rstn), .A_CSN(a_csn), .A_ADDR(a_addr), .A_WEN(a_wen), .A_BE(a_be),
        .A_DI(a_di), .A_DOUT(a_dout[1]), .A_VALID(a_vld[1]), .B_CSN(b_csn), .B_ADDR(b_addr),
        .B_DOUT(b_dout[1]), .B_VALID(b_vld[1]), .COLL(coll[1]));
    dp_sram #(.RD_LAT(2), .RDW_MODE(0), .SIZE(3000)) u2 (
        .CLK(clk), .RSTN(rstn), .A_CSN(a_csn), .A_ADDR(a_addr), .A_WEN(a_wen), .A_BE(a_be),
        .A_DI(a_di), .A_DOUT(a_dout[2]), .A_VALID(a_vld[2]), .B_CSN(b_csn), .B_ADDR(b_addr),
        .B_DOUT(b_dout[2]), .B_VALID(b_vld[2]), .COLL(coll[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_csn = 1'b1; a_wen = 1'b1; a_be = 4'h0; a_di = 32'h0; a_addr = 12'h0;
    endtask

    task automatic b_idle();
        b_csn = 1'b1; b_addr = 12'h0;
    endtask

    task automatic a_wr(input logic [11:0] ad, input logic [31:0] d, input logic [3:0] be);
        a_csn = 1'b0; a_wen = 1'b0; a_addr = ad; a_di = d; a_be = be;
    endtask

    task automatic a_rd(input logic [11:0] ad);
        a_csn = 1'b0; a_wen = 1'b1; a_addr = ad; a_be = 4'h0; a_di = 32'h0;
    endtask

    task automatic b_rd(input logic [11:0] ad);
        b_csn = 1'b0; b_addr = ad;
    endtask

    initial begin
        rstn = 1'b0;
        a_idle();
        b_idle();
        #2;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_a_dout%0d", k), a_dout[k], 32'h0);
            chk($sformatf("rst_b_dout%0d", k), b_dout[k], 32'h0);
            chk($sformatf("rst_flags%0d", k), {29'h0, a_vld[k], b_vld[k], coll[k]}, 32'h0);
        end
        tick();
        rstn = 1'b1;

        // Full write then read at address 5
        a_wr(12'd5, 32'h11223344, 4'hF);
        tick();
        chk("wr_no_valid", {31'h0, a_vld[0]}, 32'h0);
        chk("wr_keeps_dout", a_dout[0], 32'h0);
        a_rd(12'd5);
        tick();
        chk("rd1_valid", {31'h0, a_vld[0]}, 32'h1);
        chk("rd1_data", a_dout[0], 32'h11223344);
        chk("rd2_not_yet", {31'h0, a_vld[2]}, 32'h0);
        a_idle();
        tick();
        chk("rd1_pulse_end", {31'h0, a_vld[0]}, 32'h0);
        chk("rd1_hold", a_dout[0], 32'h11223344);
        chk("rd2_valid", {31'h0, a_vld[2]}, 32'h1);
        chk("rd2_data", a_dout[2], 32'h11223344);

        // Partial byte-lane write, then all-zero BE write must change nothing
        a_wr(12'd5, 32'hAABBCCDD, 4'b0101);
        tick();
        a_wr(12'd5, 32'h00000000, 4'b0000);
        tick();
        a_rd(12'd5);
        tick();
        chk("partial_data", a_dout[0], 32'h11BB33DD);
        a_idle();
        tick();
        chk("partial_data_lat2", a_dout[2], 32'h11BB33DD);

        // Same-edge A write / B read at address 9 over a zero word
        a_wr(12'd9, 32'h0, 4'hF);
        tick();
        a_wr(12'd9, 32'hFFFFFFFF, 4'hF);
        b_rd(12'd9);
        tick();
        chk("rdw_old_data", b_dout[0], 32'h0);
        chk("rdw_old_valid", {31'h0, b_vld[0]}, 32'h1);
        chk("rdw_new_data", b_dout[1], 32'hFFFFFFFF);
        chk("coll_m0", {31'h0, coll[0]}, 32'h1);
        chk("coll_m1", {31'h0, coll[1]}, 32'h1);
        chk("coll_lat2", {31'h0, coll[2]}, 32'h1);
        a_idle();
        b_rd(12'd9);
        tick();
        chk("coll_pulse_end", {31'h0, coll[0]}, 32'h0);
        chk("wr_then_b_rd", b_dout[0], 32'hFFFFFFFF);
        chk("rdw_old_lat2", b_dout[2], 32'h0);
        chk("rdw_old_lat2_vld", {31'h0, b_vld[2]}, 32'h1);
        b_idle();

        // Back-to-back B reads of addresses 0,1,2
        for (int i = 0; i < 3; i++) begin
            a_wr(12'(i), 32'h100 + 32'(i), 4'hF);
            tick();
        end
        a_idle();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) b_rd(12'(i));
            else b_idle();
            tick();
            chk($sformatf("b2b_l1_vld%0d", i), {31'h0, b_vld[0]}, {31'h0, i < 3});
            if (i < 3) chk($sformatf("b2b_l1_dat%0d", i), b_dout[0], 32'h100 + 32'(i));
            chk($sformatf("b2b_l2_vld%0d", i), {31'h0, b_vld[2]}, {31'h0, (i >= 1) && (i <= 3)});
            if (i >= 1 && i <= 3) chk($sformatf("b2b_l2_dat%0d", i), b_dout[2], 32'h100 + 32'(i - 1));
        end

        // Out-of-range on the SIZE=3000 instance (in range on SIZE=4096)
        a_wr(12'd1452, 32'h5A5A5A5A, 4'hF);
        tick();
        a_wr(12'd3500, 32'hDEADBEEF, 4'hF);
        b_rd(12'd3500);
        tick();
        chk("oor_no_coll", {31'h0, coll[2]}, 32'h0);
        chk("inrng_coll", {31'h0, coll[0]}, 32'h1);
        b_idle();
        a_rd(12'd3500);
        tick();
        chk("inrng_rd", a_dout[0], 32'hDEADBEEF);
        a_rd(12'd1452);
        tick();
        chk("oor_rd_vld", {31'h0, a_vld[2]}, 32'h1);
        chk("oor_rd_zero", a_dout[2], 32'h0);
        a_idle();
        tick();
        chk("alias_intact", a_dout[2], 32'h5A5A5A5A);

        // Reset while a read is in flight; write attempted during reset
        a_rd(12'd5);
        tick();
        rstn = 1'b0;
        #1;
        chk("arst_a_dout_l2", a_dout[2], 32'h0);
        chk("arst_a_vld_l2", {31'h0, a_vld[2]}, 32'h0);
        chk("arst_a_dout_l1", a_dout[0], 32'h0);
        a_wr(12'd9, 32'h12345678, 4'hF);
        tick();
        rstn = 1'b1;
        a_idle();
        tick();
        chk("post_rst_no_vld0", {31'h0, a_vld[2]}, 32'h0);
        tick();
        chk("post_rst_no_vld1", {31'h0, a_vld[2]}, 32'h0);
        a_rd(12'd5);
        tick();
        a_rd(12'd9);
        tick();
        chk("post_rst_l2_5", a_dout[2], 32'h11BB33DD);
        chk("post_rst_l1_9", a_dout[0], 32'hFFFFFFFF);
        a_idle();
        tick();
        chk("post_rst_l2_9", a_dout[2], 32'hFFFFFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
